// File: rtl/noc_output_scheduler_pkg.sv
// Shared NoC types for the output scheduler: QoS level, flit flags, scheduler state.
package noc_output_scheduler_pkg;

    localparam int unsigned QOS_LEVELS = 4;

    typedef logic [1:0] qos_level_t;

    typedef struct packed {
        logic head;
        logic tail;
    } flit_flags_t;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StActive = 1'b1
    } sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/noc_output_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping to index 0.
module noc_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (PtrW'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Wrap-around pass: only requesters below ptr remain.
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_scheduler.sv
// Credit-based QoS/round-robin output link scheduler with packet locking and aging.
// Define NOC_SCHED_PERF_EN to enable the pkt_count / max_wait performance counters.
module noc_output_scheduler
    import noc_output_scheduler_pkg::*;
#(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned FLIT_W  = 64,
    parameter int unsigned CREDITS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_IN-1:0]                 in_valid,
    input  logic [NUM_IN-1:0]                 in_head,
    input  logic [NUM_IN-1:0]                 in_tail,
    input  qos_level_t [NUM_IN-1:0]           in_qos,
    input  logic [NUM_IN-1:0][FLIT_W-1:0]     in_flit,
    output logic [NUM_IN-1:0]                 in_ready,
    output logic                              out_valid,
    output logic [FLIT_W-1:0]                 out_flit,
    output logic [NUM_IN-1:0]                 out_src,
    input  logic                              credit_in,
    input  logic [7:0]                        aging_threshold,
    input  logic                              fairness_enable,
    output logic                              credit_err,
    output logic                              busy,
    output logic [QOS_LEVELS-1:0][31:0]       pkt_count,
    output logic [7:0]                        max_wait
);

    localparam int unsigned CntW = $clog2(CREDITS + 1);
    localparam int unsigned PtrW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    sched_state_t                      state_q, state_d;
    logic [NUM_IN-1:0]                 owner_q, owner_d;
    logic [CntW-1:0]                   credit_q, credit_d;
    logic                              credit_err_q, credit_err_d;
    logic [QOS_LEVELS-1:0][PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_IN-1:0][7:0]            wait_q, wait_d;

    flit_flags_t [NUM_IN-1:0]          in_flags;
    logic [NUM_IN-1:0]                 cand, aged, aged_pick, sel;
    logic [QOS_LEVELS-1:0][NUM_IN-1:0] lvl_req, lvl_grant;
    qos_level_t                        top_lvl, xfer_qos;
    logic                              use_aged, credit_ok, credit_full, xfer, xfer_tail;
    logic [PtrW-1:0]                   next_ptr;
    logic [FLIT_W-1:0]                 xfer_flit;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_flags[i].head = in_head[i];
            in_flags[i].tail = in_tail[i];
            cand[i]          = in_valid[i] && in_flags[i].head;
            aged[i]          = cand[i] && (wait_q[i] >= aging_threshold);
        end
        for (int unsigned l = 0; l < QOS_LEVELS; l++) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                lvl_req[l][i] = cand[i] && (in_qos[i] == qos_level_t'(l));
            end
        end
    end

    for (genvar l = 0; l < QOS_LEVELS; l++) begin : g_arb
        noc_rr_arbiter #(
            .N    (NUM_IN),
            .PtrW (PtrW)
        ) u_arb (
            .req   (lvl_req[l]),
            .ptr   (rr_ptr_q[l]),
            .grant (lvl_grant[l])
        );
    end

    always_comb begin
        top_lvl   = '0;
        aged_pick = '0;
        for (int unsigned l = 0; l < QOS_LEVELS; l++) begin
            if (|lvl_req[l]) top_lvl = qos_level_t'(l);
        end
        for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
            if (aged[i]) begin
                aged_pick    = '0;
                aged_pick[i] = 1'b1;
            end
        end
        use_aged    = fairness_enable && (|aged);
        credit_ok   = (credit_q != '0);
        credit_full = (credit_q == CntW'(CREDITS));
        if (state_q == StActive) begin
            sel = owner_q;
        end else begin
            sel = use_aged ? aged_pick : lvl_grant[top_lvl];
        end
        in_ready = sel & in_valid & {NUM_IN{credit_ok}};
        xfer     = |in_ready;
    end

    // in_ready is one-hot or zero, so OR-muxing extracts the transferring flit.
    always_comb begin
        xfer_tail = 1'b0;
        xfer_qos  = '0;
        next_ptr  = '0;
        xfer_flit = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_ready[i]) begin
                xfer_tail = in_flags[i].tail;
                xfer_qos  = in_qos[i];
                next_ptr  = (i == NUM_IN - 1) ? '0 : PtrW'(i + 1);
            end
            xfer_flit = xfer_flit | ({FLIT_W{in_ready[i]}} & in_flit[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    rr_ptr_d[xfer_qos] = next_ptr;
                    if (!xfer_tail) begin
                        state_d = StActive;
                        owner_d = in_ready;
                    end
                end
            end
            StActive: begin
                if (xfer && xfer_tail) begin
                    state_d = StIdle;
                    owner_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (credit_in) begin
            if (credit_full) credit_err_d = 1'b1;
            else             credit_d     = credit_d + CntW'(1);
        end
        if (xfer) credit_d = credit_d - CntW'(1);
    end

    // Any input holding a head flit ages while it waits, including during another packet.
    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!in_valid[i] || in_ready[i]) wait_d[i] = '0;
            else if (cand[i])                wait_d[i] = sat_inc8(wait_q[i]);
            else                             wait_d[i] = wait_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            credit_q     <= CntW'(CREDITS);
            credit_err_q <= 1'b0;
            rr_ptr_q     <= '0;
            wait_q       <= '0;
            out_valid    <= 1'b0;
            out_flit     <= '0;
            out_src      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            rr_ptr_q     <= rr_ptr_d;
            wait_q       <= wait_d;
            out_valid    <= xfer;
            out_src      <= in_ready;
            if (xfer) out_flit <= xfer_flit;
        end
    end

    assign busy       = (state_q == StActive);
    assign credit_err = credit_err_q;

`ifdef NOC_SCHED_PERF_EN
    logic [QOS_LEVELS-1:0][31:0] pkt_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
        end else if (xfer && xfer_tail) begin
            pkt_count_q[xfer_qos] <= pkt_count_q[xfer_qos] + 32'd1;
        end
    end

    always_comb begin
        max_wait = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (wait_q[i] > max_wait) max_wait = wait_q[i];
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
    assign max_wait  = '0;
`endif

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Self-checking bench for noc_output_scheduler: directed vector table, reset sequence,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_noc_output_scheduler;
    import noc_output_scheduler_pkg::*;

    localparam int N    = 4;
    localparam int FW   = 64;
    localparam int CRED = 8;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [N-1:0]                 in_valid, in_head, in_tail, in_ready, out_src;
    qos_level_t [N-1:0]           in_qos;
    logic [N-1:0][FW-1:0]         in_flit;
    logic                         out_valid;
    logic [FW-1:0]                out_flit;
    logic                         credit_in;
    logic [7:0]                   aging_threshold;
    logic                         fairness_enable;
    logic                         credit_err, busy;
    logic [QOS_LEVELS-1:0][31:0]  pkt_count;
    logic [7:0]                   max_wait;

    noc_output_scheduler #(
        .NUM_IN  (N),
        .FLIT_W  (FW),
        .CREDITS (CRED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_head         (in_head),
        .in_tail         (in_tail),
        .in_qos          (in_qos),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_flit        (out_flit),
        .out_src         (out_src),
        .credit_in       (credit_in),
        .aging_threshold (aging_threshold),
        .fairness_enable (fairness_enable),
        .credit_err      (credit_err),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .max_wait        (max_wait)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit           m_active;
    int           m_owner;
    int           m_cred;
    int           m_rr[4];
    int           m_wait[N];
    bit           m_err;
    bit           m_ov;
    logic [N-1:0] m_src;
    logic [FW-1:0] m_flit;
    logic [N-1:0] m_ready;

    typedef struct {
        logic         rst;
        logic         fair;
        logic [7:0]   thr;
        logic [N-1:0] v, h, t;
        logic [7:0]   qos;
        logic         cin;
        logic [N-1:0] e_ready;
        logic         e_busy;
        logic         e_ov;
        logic [N-1:0] e_src;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic fair, logic [7:0] thr, logic [N-1:0] v,
                                logic [N-1:0] h, logic [N-1:0] t, logic [7:0] qos, logic cin,
                                logic [N-1:0] e_ready, logic e_busy, logic e_ov,
                                logic [N-1:0] e_src);
        vec_t r;
        r.rst = rst; r.fair = fair; r.thr = thr; r.v = v; r.h = h; r.t = t; r.qos = qos;
        r.cin = cin; r.e_ready = e_ready; r.e_busy = e_busy; r.e_ov = e_ov; r.e_src = e_src;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_head = '0; in_tail = '0; in_qos = '0; in_flit = '0;
        credit_in = 1'b0;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_owner = -1; m_cred = CRED; m_err = 1'b0;
        m_ov = 1'b0; m_src = '0; m_flit = '0;
        foreach (m_rr[l]) m_rr[l] = 0;
        foreach (m_wait[i]) m_wait[i] = 0;
    endtask

    function automatic bit is_cand(int i);
        return in_valid[i] && in_head[i];
    endfunction

    // Which input the link should serve this cycle, from the arbitration rules.
    function automatic logic [N-1:0] model_pick();
        logic [N-1:0] r = '0;
        int best = -1;
        if (m_cred == 0) return r;
        if (m_active) begin
            if (in_valid[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        if (fairness_enable) begin
            for (int i = 0; i < N; i++) begin
                if (is_cand(i) && m_wait[i] >= int'(aging_threshold)) begin
                    r[i] = 1'b1;
                    return r;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (is_cand(i) && int'(in_qos[i]) > best) best = int'(in_qos[i]);
        if (best < 0) return r;
        for (int k = 0; k < N; k++) begin
            int i = (m_rr[best] + k) % N;
            if (is_cand(i) && int'(in_qos[i]) == best) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_seq();
        int w = -1;
        for (int i = 0; i < N; i++) if (m_ready[i]) w = i;
        for (int i = 0; i < N; i++) begin
            if (!in_valid[i] || m_ready[i]) m_wait[i] = 0;
            else if (in_head[i] && m_wait[i] < 255) m_wait[i]++;
        end
        if (w >= 0) begin
            if (!m_active) begin
                m_rr[in_qos[w]] = (w + 1) % N;
                if (!in_tail[w]) begin
                    m_active = 1'b1;
                    m_owner  = w;
                end
            end else if (in_tail[w]) begin
                m_active = 1'b0;
                m_owner  = -1;
            end
        end
        if (credit_in) begin
            if (m_cred == CRED) m_err = 1'b1;
            else                m_cred++;
        end
        if (w >= 0) begin
            m_cred--;
            m_flit = in_flit[w];
        end
        m_ov  = (w >= 0);
        m_src = m_ready;
    endtask

    task automatic settle();
        @(negedge clk);
        m_ready = model_pick();
        check("in_ready", in_ready, m_ready);
        check("busy", busy, m_active);
        check("out_valid", out_valid, m_ov);
        check("out_src", out_src, m_src);
        if (m_ov) check("out_flit", out_flit, m_flit);
        check("credit_err", credit_err, m_err);
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int cprob[3] = '{30, 60, 15};

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        fairness_enable = 1'b0;
        aging_threshold = 8'd255;
        model_reset();

        // Single 3-flit packet on input 0, then qos 3 beats qos 1
        tbl.push_back(mk(1, 0, 255, 4'b0001, 4'b0001, 4'b0000, 8'h00, 0, 4'b0001, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b0001, 4'b0000, 4'b0000, 8'h00, 0, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk(0, 0, 255, 4'b0001, 4'b0000, 4'b0001, 8'h00, 0, 4'b0001, 1, 1, 4'b0001));
        tbl.push_back(mk(0, 0, 255, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b0000, 0, 1, 4'b0001));
        tbl.push_back(mk(0, 0, 255, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b1010, 4'b1010, 4'b0000, 8'hC4, 0, 4'b1000, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b1010, 4'b0010, 4'b1000, 8'hC4, 0, 4'b1000, 1, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 255, 4'b0010, 4'b0010, 4'b0000, 8'hC4, 0, 4'b0010, 0, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 255, 4'b0010, 4'b0000, 4'b0010, 8'hC4, 0, 4'b0010, 1, 1, 4'b0010));
        tbl.push_back(mk(0, 0, 255, 4'b0000, 4'b0000, 4'b0000, 8'hC4, 0, 4'b0000, 0, 1, 4'b0010));
        // Round-robin 0/2 at qos 2, credit exhaustion and return
        tbl.push_back(mk(1, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0, 4'b0001, 0, 0, 4'b0000));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0,
                             (k % 2 == 0) ? 4'b0100 : 4'b0001, 0, 1,
                             (k % 2 == 0) ? 4'b0001 : 4'b0100));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0, 4'b0000, 0, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 1, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0, 4'b0001, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 1, 4'b0000, 0, 1, 4'b0001));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 1, 4'b0100, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0, 4'b0001, 0, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 255, 4'b0101, 4'b0101, 4'b0101, 8'h22, 0, 4'b0000, 0, 1, 4'b0001));
        // Aging: qos 0 input 0 overtakes qos 3 traffic once its wait reaches 3
        tbl.push_back(mk(1, 1, 3, 4'b1001, 4'b1001, 4'b0000, 8'hC0, 0, 4'b1000, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 3, 4'b1001, 4'b0001, 4'b1000, 8'hC0, 0, 4'b1000, 1, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 4'b1001, 4'b1001, 4'b0000, 8'hC0, 0, 4'b1000, 0, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 4'b1001, 4'b0001, 4'b1000, 8'hC0, 0, 4'b1000, 1, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 4'b1001, 4'b1001, 4'b0001, 8'hC0, 0, 4'b0001, 0, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 3, 4'b1000, 4'b1000, 4'b1000, 8'hC0, 0, 4'b1000, 0, 1, 4'b0001));
        tbl.push_back(mk(0, 1, 3, 4'b0000, 4'b0000, 4'b0000, 8'hC0, 0, 4'b0000, 0, 1, 4'b1000));

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            fairness_enable = tbl[k].fair;
            aging_threshold = tbl[k].thr;
            in_valid  = tbl[k].v;
            in_head   = tbl[k].h;
            in_tail   = tbl[k].t;
            credit_in = tbl[k].cin;
            for (int i = 0; i < N; i++) begin
                in_qos[i]  = qos_level_t'(tbl[k].qos[2*i +: 2]);
                in_flit[i] = {32'(i), 32'(k)};
            end
            settle();
            check("tbl_ready", in_ready, tbl[k].e_ready);
            check("tbl_busy", busy, tbl[k].e_busy);
            check("tbl_out_valid", out_valid, tbl[k].e_ov);
            check("tbl_out_src", out_src, tbl[k].e_src);
            advance();
        end

        // Reset in the middle of a packet, then credit overflow at full
        do_reset();
        fairness_enable = 1'b0;
        aging_threshold = 8'd255;
        in_valid = 4'b0010; in_head = 4'b0010; in_flit[1] = 64'hABCD;
        settle();
        advance();
        in_head = 4'b0000;
        settle();
        check("busy_mid_packet", busy, 1'b1);
        advance();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_src", out_src, 4'b0000);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        check("post_rst_ready", in_ready, 4'b0000);
        check("post_rst_out_valid", out_valid, 1'b0);
        advance();
        in_valid  = 4'b0000;
        credit_in = 1'b1;
        settle();
        check("credit_err_pre", credit_err, 1'b0);
        advance();
        credit_in = 1'b0;
        settle();
        check("credit_err_set", credit_err, 1'b1);
        advance();
        in_valid = 4'b0100; in_head = 4'b0100; in_tail = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            in_flit[2] = 64'(c);
            settle();
            check("credits_after_rst", in_ready[2], c < CRED);
            advance();
        end

        // Randomized traffic against the model
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            fairness_enable = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < N; i++) begin
                    in_valid[i] = ($urandom_range(99) < 70);
                    in_head[i]  = ($urandom_range(1) == 1);
                    in_tail[i]  = ($urandom_range(99) < 40);
                    in_qos[i]   = qos_level_t'($urandom_range(3));
                    in_flit[i]  = {$urandom, $urandom};
                end
                credit_in = ($urandom_range(99) < cprob[ph]);
                if (c % 100 == 0) begin
                    aging_threshold = 8'($urandom_range(6));
                    fairness_enable = (ph == 1) ? 1'b1 : (ph == 2) ? ($urandom_range(1) == 1) : 1'b0;
                end
                settle();
                advance();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_output_scheduler.md
NOC_OUTPUT_SCHEDULER -- requirements
Module: noc_output_scheduler

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of input ports sharing one output link.
REQ-002 SHALL have parameter FLIT_W, default 64: flit data width.
REQ-003 SHALL have parameter CREDITS, default 8: downstream buffer slots; credit counter width $clog2(CREDITS+1).
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have ports: in_valid  in  NUM_IN  flit present per input; in_head  in  NUM_IN  head flag; in_tail  in  NUM_IN  tail flag; in_qos  in  qos_level_t[NUM_IN]  priority per input; in_flit  in  FLIT_W[NUM_IN]  data; in_ready  out  NUM_IN  flit accepted this cycle.
REQ-006 SHALL have ports: out_valid  out  1  registered flit valid; out_flit  out  FLIT_W  registered data; out_src  out  NUM_IN  one-hot source of out_flit; credit_in  in  1  one-slot credit return pulse.
REQ-007 SHALL have ports: aging_threshold  in  8  wait cycles before aged priority; fairness_enable  in  1  enables aging override; credit_err  out  1  sticky credit overflow flag; busy  out  1  packet in progress.

Function
REQ-008 SHALL implement states IDLE (no owner) and ACTIVE (owner input holds the link until its tail flit transfers).
REQ-009 In IDLE, candidates SHALL be inputs with in_valid&&in_head; winner = aged candidate with lowest index if fairness_enable and any candidate wait count >= aging_threshold, else highest in_qos level, round-robin within that level.
REQ-010 Round-robin pointer per QoS level SHALL advance to the input after the winner only when a head flit of that level transfers.
REQ-011 A transfer SHALL occur when selected/owner input has in_valid and credit count > 0; in_ready SHALL be combinational, one-hot or zero, asserted only for a transferring input.
REQ-012 Head transfer without tail SHALL move IDLE->ACTIVE with owner latched; head+tail (single-flit) SHALL remain IDLE.
REQ-013 In ACTIVE only the owner SHALL be served, ignoring in_head on other inputs; tail transfer SHALL return to IDLE next cycle; owner bubbles (in_valid low) SHALL hold ACTIVE.
REQ-014 out_valid/out_flit/out_src SHALL be registered: a transfer in cycle N appears in cycle N+1; out_valid low otherwise.
REQ-015 Credit counter: -1 on transfer, +1 on credit_in, unchanged on both; credit_in at CREDITS SHALL be ignored and set credit_err until reset.
REQ-016 Per-input wait counter SHALL increment (saturate 255) each cycle the input is a head candidate and not transferred, clear on its head transfer or when in_valid drops.
REQ-017 busy SHALL equal (state == ACTIVE).

Reset
REQ-018 On rst_n low, asynchronously: state IDLE, owner none, credits = CREDITS, RR pointers = input 0, wait counters 0, out_valid 0, out_flit 0, out_src 0, credit_err 0, busy 0.
REQ-019 Reset mid-packet SHALL abandon the packet; no flit is emitted in the first cycle after deassertion.

Configuration
REQ-020 With NOC_SCHED_PERF_EN defined, SHALL add outputs pkt_count (qos_level_t-indexed 32-bit, +1 per tail transfer of that level, wrap) and max_wait (8-bit, max current wait counter); without it these outputs SHALL exist and be tied 0 with no counter logic.

Structure
REQ-021 qos_level_t (2-bit), QOS_LEVELS=4 and flit flag typedefs SHALL come from the shared noc package; no local redefinition.
REQ-022 One sub-module noc_rr_arbiter (request vector, pointer, one-hot grant) SHALL be instantiated per QoS level.

Verification
REQ-023 Single input 0, 3-flit packet (head, body, tail), credits 8 -> out_valid cycles 1-3, out_src 0001, credits 5, busy high cycles 1-2 after head.
REQ-024 Inputs 1 (qos 1) and 3 (qos 3) heads same cycle -> input 3 granted first; input 1 granted after input 3 tail.
REQ-025 Inputs 0,2 qos 2, four single-flit packets each -> grants alternate 0,2,0,2,...
REQ-026 Credits exhausted (8 flits sent, no credit_in) -> in_ready 0; one credit_in pulse -> exactly one flit; credit_in plus transfer same cycle -> count unchanged.
REQ-027 fairness_enable=1, aging_threshold=3, input 0 qos 0 blocked by qos 3 traffic -> input 0 granted at the first head arbitration once its wait count >= 3.
REQ-028 rst_n pulsed mid-ACTIVE, credit_in at full -> state IDLE, credits 8, out_valid 0; credit_in at full sets credit_err.
